// File: rtl/cmp_pkg.sv
// Shared constants and FSM encoding for the memory compare engine.
// Default sizes match Top_controller's result/golden memory sizing.
package cmp_pkg;

    localparam int DEF_DATA_W = 22;
    localparam int DEF_DEPTH  = 4096;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } cmp_state_e;

endpackage

// File: rtl/rd_lat_pipe.sv
// STAGES-deep valid+address shift register that tracks each read until its
// data returns from the memories.
module rd_lat_pipe #(
    parameter int ADDR_W = 12,
    parameter int STAGES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_vld,
    input  logic [ADDR_W-1:0] in_addr,
    output logic              out_vld,
    output logic [ADDR_W-1:0] out_addr,
    output logic              any_vld
);

    logic [STAGES-1:0]             vld_pipe;
    logic [STAGES-1:0][ADDR_W-1:0] addr_pipe;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe  <= '0;
            addr_pipe <= '0;
        end else begin
            vld_pipe[0]  <= in_vld;
            addr_pipe[0] <= in_addr;
            for (int i = 1; i < STAGES; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                addr_pipe[i] <= addr_pipe[i-1];
            end
        end
    end

    assign out_vld  = vld_pipe[STAGES-1];
    assign out_addr = addr_pipe[STAGES-1];
    assign any_vld  = |vld_pipe;

endmodule

// File: rtl/mem_compare_engine.sv
// Sweeps result and golden memories with a shared address and reports mismatches.
// Define MISMATCH_CAPTURE_EN to also capture the data words of the first mismatch.
module mem_compare_engine
    import cmp_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int RD_LAT = 1,
    parameter int TOL    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] dut_rdata,
    input  logic [DATA_W-1:0] gold_rdata,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   err_cnt,
    output logic              first_err_valid,
`ifdef MISMATCH_CAPTURE_EN
    output logic [DATA_W-1:0] first_err_dut,
    output logic [DATA_W-1:0] first_err_gold,
`endif
    output logic [ADDR_W-1:0] first_err_addr
);

    localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W+1)'(DEPTH);
    localparam logic [DATA_W-1:0] TOL_V   = DATA_W'(TOL);
    localparam logic [ADDR_W:0]   ERR_MAX = '1;

    cmp_state_e        state, state_nxt;
    logic [ADDR_W-1:0] last_addr;
    logic [ADDR_W-1:0] len_last;
    logic [ADDR_W:0]   len_m1;
    logic              start_ok;
    logic              issue_last;
    logic              tail_vld;
    logic [ADDR_W-1:0] tail_addr;
    logic              pipe_busy;
    logic [DATA_W-1:0] diff;
    logic              mism;

    assign start_ok   = start && (state == ST_IDLE);
    assign issue_last = (rd_addr == last_addr);

    // A zero or oversized length means a full-depth sweep.
    assign len_m1   = len - 1'b1;
    assign len_last = (len == '0 || len > DEPTH_W) ? ADDR_W'(DEPTH - 1) : len_m1[ADDR_W-1:0];

    rd_lat_pipe #(
        .ADDR_W (ADDR_W),
        .STAGES (RD_LAT)
    ) u_pipe (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (rd_en),
        .in_addr  (rd_addr),
        .out_vld  (tail_vld),
        .out_addr (tail_addr),
        .any_vld  (pipe_busy)
    );

    // Larger minus smaller never wraps, so DATA_W bits suffice.
    assign diff = (dut_rdata > gold_rdata) ? (dut_rdata - gold_rdata) : (gold_rdata - dut_rdata);
    assign mism = tail_vld && (diff > TOL_V);

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start)       state_nxt = ST_ISSUE;
            ST_ISSUE: if (issue_last)  state_nxt = ST_DRAIN;
            ST_DRAIN: if (!pipe_busy)  state_nxt = ST_FIN;
            ST_FIN:                    state_nxt = ST_IDLE;
            default:                   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_en = (state == ST_ISSUE);
        busy  = (state != ST_IDLE);
        done  = (state == ST_FIN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_addr       <= '0;
            rd_addr         <= '0;
            err_cnt         <= '0;
            first_err_valid <= 1'b0;
            first_err_addr  <= '0;
            pass            <= 1'b0;
`ifdef MISMATCH_CAPTURE_EN
            first_err_dut   <= '0;
            first_err_gold  <= '0;
`endif
        end else begin
            if (start_ok) begin
                last_addr       <= len_last;
                rd_addr         <= '0;
                err_cnt         <= '0;
                first_err_valid <= 1'b0;
                first_err_addr  <= '0;
                pass            <= 1'b0;
`ifdef MISMATCH_CAPTURE_EN
                first_err_dut   <= '0;
                first_err_gold  <= '0;
`endif
            end else if (state == ST_ISSUE && !issue_last) begin
                rd_addr <= rd_addr + 1'b1;
            end

            if (mism) begin
                if (err_cnt != ERR_MAX) err_cnt <= err_cnt + 1'b1;
                if (!first_err_valid) begin
                    first_err_valid <= 1'b1;
                    first_err_addr  <= tail_addr;
`ifdef MISMATCH_CAPTURE_EN
                    first_err_dut   <= dut_rdata;
                    first_err_gold  <= gold_rdata;
`endif
                end
            end

            // Counters are final once the pipe is empty, so pass is ready with done.
            if (state == ST_DRAIN && !pipe_busy) pass <= (err_cnt == '0);
        end
    end

endmodule

// File: doc/mem_compare_engine.md
Name: mem_compare_engine

Overview:
- Synthesizable successor to the bench-side result check of the matrix-multiply top.
- On `start`, it sweeps a shared address over the result memory (DUT) and a golden memory. It compares word-by-word, with an optional absolute tolerance.
- It reports the error count, the first-mismatch address and a pass flag.
- Sits beside Top_controller. It is triggered by that controller's `done`, so regressions and FPGA runs self-check without a testbench loop.

Parameters:
- DATA_W, 22, width of compared words.
- DEPTH, 4096, maximum words per sweep.
- ADDR_W, $clog2(DEPTH), address width.
- RD_LAT, 1, memory read latency in cycles (1..4).
- TOL, 0, maximum accepted unsigned |dut-gold|; 0 means exact match.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a sweep; honoured only when busy=0.
- len  in  ADDR_W+1  words to check, sampled at start; 0 or >DEPTH is treated as DEPTH.
- rd_en  out  1  read strobe to both memories.
- rd_addr  out  ADDR_W  shared read address.
- dut_rdata  in  DATA_W  DUT memory data, valid RD_LAT cycles after rd_en.
- gold_rdata  in  DATA_W  golden memory data, same timing.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse at sweep end.
- pass  out  1  err_cnt==0; valid from done until the next start.
- err_cnt  out  ADDR_W+1  mismatch count, saturating at all-ones.
- first_err_valid  out  1  at least one mismatch seen.
- first_err_addr  out  ADDR_W  address of the earliest mismatch.

Behaviour:
- Reset: every output is 0 and the FSM is in IDLE. Reset mid-sweep aborts immediately: no done pulse, all results cleared.
- FSM states:
  - IDLE, start -> ISSUE. On the start cycle, latch len, clear err_cnt, first_err_* and pass, and set rd_addr=0.
  - ISSUE: rd_en=1 every cycle, rd_addr increments. After the issue at address len-1 -> DRAIN.
  - DRAIN: rd_en=0; wait until the RD_LAT-deep valid pipeline empties -> FIN.
  - FIN: done=1 for one cycle; pass=(err_cnt==0) is registered; -> IDLE.
- Valid/address pipeline: a shift register of RD_LAT stages carries (valid, addr) alongside each read.
- Compare: occurs when the pipeline tail is valid; the compare result is registered one cycle later into the counters.
- Mismatch rule: (dut>gold ? dut-gold : gold-dut) > TOL.
  - Subtraction is DATA_W-bit unsigned with no overflow, because the larger operand minus the smaller never wraps.
- first_err_addr: written only on the first mismatch of a sweep; later mismatches are ignored.
- Latency: start to done = 1 + len + RD_LAT + 1 cycles. Example: len=4096, RD_LAT=1 gives 4099.
- busy: 1 from the cycle after start through the FIN cycle. done and busy are both high during FIN.
- Start handling:
  - start while busy=1 is ignored.
  - start in the cycle after FIN is accepted normally.
  - Back-to-back sweeps need no idle gap beyond IDLE.
- len=1: exactly one read; done after RD_LAT+3 cycles.
- rd_addr wraps only via the len rule and never exceeds DEPTH-1.

Optional Feature:
- Macro: MISMATCH_CAPTURE_EN.
- When defined:
  - Adds outputs first_err_dut and first_err_gold (DATA_W each).
  - They are latched together with first_err_addr, cleared at start and at reset.
- When undefined: those ports and registers do not exist. All other behaviour is identical.

Decomposition:
- Shared package/header cmp_pkg holds:
  - FSM state encodings (IDLE=0, ISSUE=1, DRAIN=2, FIN=3).
  - The default DATA_W=22 and DEPTH=4096 constants, shared with Top_controller's memory sizing.
- One natural sub-module, rd_lat_pipe: a parametrised RD_LAT-stage valid+address shift register.
- Compare logic, counters and FSM stay in the top.

Test Plan:
- Identical memories, len=4096, RD_LAT=1, TOL=0 -> done 4099 cycles after start; pass=1, err_cnt=0, first_err_valid=0.
- Mismatches injected at addresses 17, 18 and 4095 -> err_cnt=3, first_err_addr=17, pass=0. With MISMATCH_CAPTURE_EN, first_err_dut and first_err_gold equal the injected words.
- TOL=2; word 5 has dut=0x000100, gold=0x000102; word 9 has dut=0x3FFFFF, gold=0x000000 -> err_cnt=1, first_err_addr=9.
- RD_LAT=3, len=1, mismatch at addr 0 -> done exactly 6 cycles after start; err_cnt=1.
- rst asserted at the 100th cycle of a sweep, then released -> outputs all 0, no done pulse; a new start completes a normal sweep.
- start pulsed while busy, then again in the cycle after FIN -> first extra start ignored, second sweep runs with the new len=8 and done 11 cycles later (RD_LAT=1).
